quotient_bcd_converter: RTL
===========================

QUOTIENT_BCD_CONVERTER -- requirements
Module: quotient_bcd_converter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the binary input width (the quotient width).
REQ-002 The block SHALL have parameter DIGITS, default 10, giving the number of BCD output digits; it must satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; synchronous, active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning in_data holds a quotient to convert.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits, the unsigned binary quotient.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning out_bcd and out_ndigits hold a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result this cycle.
REQ-010 The block SHALL have port out_bcd, output, 4*DIGITS bits, packed BCD with digit 0 (units) in bits [3:0].
REQ-011 The block SHALL have port out_ndigits, output, 4 bits, the count of significant digits: 1 for value 0, otherwise the index of the highest nonzero digit plus 1.
REQ-012 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-013 The block SHALL be a three-state FSM with states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL equal (state == IDLE); there is no bypass and no input buffering.
REQ-015 A transfer SHALL occur on an edge where in_valid and in_ready are both 1; that edge loads in_data into a WIDTH-bit shift register, clears the BCD accumulator and the iteration counter, and moves to SHIFT.
REQ-016 Each SHIFT edge SHALL first add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one bit, and then increment the counter.
REQ-017 After the WIDTH-th SHIFT edge the block SHALL enter DONE with out_valid=1; at default parameters out_valid rises on the 32nd edge after the accepting edge.
REQ-018 out_ndigits SHALL be registered so that it is valid in the same cycle as out_valid.
REQ-019 In DONE, out_bcd and out_ndigits SHALL hold stable while out_ready=0, for any number of cycles.
REQ-020 In DONE with out_ready=1, the block SHALL return to IDLE on that edge with out_valid=0; the earliest next acceptance is the following edge (throughput one result per WIDTH+2 cycles).
REQ-021 in_valid and in_data SHALL be ignored in SHIFT and DONE; a held request is accepted once the block is back in IDLE.
REQ-022 No intermediate accumulator value SHALL contain a digit > 9, and the final result SHALL exactly equal the decimal value of in_data for all inputs 0 .. 2^WIDTH-1.
REQ-023 out_bcd and out_ndigits SHALL be driven from registers only; they change only on the edge that enters DONE.

Reset
REQ-024 With rst=1 at an edge, the block SHALL go to IDLE with in_ready=1, out_valid=0, busy=0, out_bcd=0 and out_ndigits=1; rst SHALL take priority over every other input.
REQ-025 A reset in SHIFT or DONE SHALL abandon the conversion and produce no output for it; the first request after rst deasserts SHALL convert correctly.

Verification
REQ-026 in_data=0 -> out_bcd=0x0000000000, out_ndigits=1, out_valid on the 32nd edge after acceptance.
REQ-027 in_data=32'hFFFFFFFF -> out_bcd=0x4294967295, out_ndigits=10.
REQ-028 in_data=12345 with out_ready=0 for 5 cycles after out_valid -> out_bcd=0x0000012345 and out_ndigits=5 held for all 5 cycles; released on the edge where out_ready=1, and in_ready=1 in the next cycle.
REQ-029 in_valid held with in_data=7, then changed to 99 during SHIFT -> the result is 7 (out_ndigits=1); 99 is accepted only after the return to IDLE.
REQ-030 rst pulsed at SHIFT iteration 10 of in_data=1000 -> no out_valid for that conversion; the next request 1000 gives out_bcd=0x0000001000, out_ndigits=4.
REQ-031 10,000 random in_data with random out_ready stalls, checked against a decimal reference model -> zero mismatches and no accumulator digit > 9.

Source files
------------

// File: rtl/quotient_bcd_converter.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method.
// One handshake in, WIDTH shift cycles, then the result is held until the consumer takes it.
module quotient_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [3:0]            out_ndigits,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [WIDTH-1:0]       shift_r;
  logic [BCD_W-1:0]       acc_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [BCD_W-1:0]       out_bcd_r;
  logic [3:0]             out_ndigits_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic                   busy_r;

  logic [BCD_W-1:0]       acc_adj_s;
  logic [BCD_W+WIDTH-1:0] shift_wide_s;
  logic [BCD_W-1:0]       acc_next_s;
  logic [WIDTH-1:0]       shift_next_s;
  logic                   last_s;

  // Digits of 5..9 become 8..12 so that the following doubling carries into the next digit.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] count_digits(input logic [BCD_W-1:0] bcd);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        n = 4'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Next-state logic and the combinational shift-and-adjust datapath.
  always_comb begin
    state_next_s = state_r;
    acc_adj_s    = add3_digits(acc_r);
    shift_wide_s = {acc_adj_s, shift_r} << 1'b1;
    acc_next_s   = shift_wide_s[BCD_W+WIDTH-1 -: BCD_W];
    shift_next_s = shift_wide_s[WIDTH-1:0];
    last_s       = (cnt_r == CNT_W'(WIDTH - 1));
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      shift_r       <= {WIDTH{1'b0}};
      acc_r         <= {BCD_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      out_bcd_r     <= {BCD_W{1'b0}};
      out_ndigits_r <= 4'd1;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shift_r <= in_data;
            acc_r   <= {BCD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        SHIFT: begin
          acc_r   <= acc_next_s;
          shift_r <= shift_next_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          // The result is captured from the final shift so it is valid alongside out_valid.
          if (last_s) begin
            out_bcd_r     <= acc_next_s;
            out_ndigits_r <= count_digits(acc_next_s);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign out_bcd     = out_bcd_r;
  assign out_ndigits = out_ndigits_r;

endmodule
